// File: rtl/fir_pkg.sv
// Shared sample format definitions for the FIR filter chain.
package fir_pkg;

  localparam int unsigned SAMPLE_W    = 14;
  localparam int unsigned SAMPLE_FRAC = 13;
  localparam int          SAMPLE_MAX  = 8191;
  localparam int          SAMPLE_MIN  = -8192;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; no fall-through, head holds when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, empty_q;
  logic             pop_ok_c, push_ok_c;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok_c  = pop && !empty_q;
  assign push_ok_c = push && (!full_q || pop_ok_c);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push_ok_c, pop_ok_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // Head tracks the oldest stored word; the incoming word only when nothing older remains.
    if (pop_ok_c && (level_q > LVL_W'(1))) begin
      head_d = mem_q[rd_ptr_d];
    end else if (push_ok_c && (empty_q || pop_ok_c)) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      full_q   <= (level_d == LVL_W'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = head_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/fir_decimator_out.sv
// Integrate-and-dump decimator (round-half-up) on the FIR output, buffered behind valid/ready.
module fir_decimator_out
  import fir_pkg::*;
#(
  parameter int unsigned LOG2_DECIM = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  sample_t                       data_in,
  input  logic                          clr_ovf,
  output sample_t                       dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned ACC_W = SAMPLE_W + LOG2_DECIM;
  localparam int unsigned RND_W = ACC_W + 1;
  localparam logic signed [RND_W-1:0] HALF    = RND_W'(2 ** (LOG2_DECIM - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(SAMPLE_MAX);
  localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(SAMPLE_MIN);

  logic [LOG2_DECIM-1:0]   phase_q, phase_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic signed [RND_W-1:0] sum_c, rnd_c, shr_c;
  sample_t                 result_c;
  logic                    dump_c, drop_c;
  logic                    fifo_full, fifo_empty;

  assign dump_c = in_valid && (phase_q == '1);
  // A full FIFO always has a head, so a pop happens exactly when the consumer is ready.
  assign drop_c = dump_c && fifo_full && !dout_ready;

  // Rounded average of the completed block; the clamp is a safety net only.
  always_comb begin
    sum_c = RND_W'(acc_q) + RND_W'(data_in);
    rnd_c = sum_c + HALF;
    shr_c = rnd_c >>> LOG2_DECIM;
    if (shr_c > SAT_MAX)      result_c = SAMPLE_W'(SAT_MAX);
    else if (shr_c < SAT_MIN) result_c = SAMPLE_W'(SAT_MIN);
    else                      result_c = SAMPLE_W'(shr_c);
  end

  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      phase_d = phase_q + LOG2_DECIM'(1);
      acc_d   = dump_c ? '0 : ACC_W'(sum_c);
    end
    if (drop_c)       ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dump_c),
    .pop   (dout_ready),
    .wdata (result_c),
    .rdata (dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign dout_valid = !fifo_empty;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_decimator_out.sv
// Randomized and directed bench for fir_decimator_out against a queue-based reference.
module tb_fir_decimator_out;

  localparam int L     = 2;
  localparam int NDEC  = 4;
  localparam int DEPTH = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic signed [13:0] data_in;
  logic              clr_ovf;
  logic signed [13:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [2:0]        fifo_level;
  logic              overflow;

  int vectors = 0;
  int errors  = 0;

  int mq[$];
  int blk[$];
  bit m_ovf;
  int m_last;
  int got[$];
  int expq[$];

  fir_decimator_out #(
    .LOG2_DECIM (L),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .clr_ovf    (clr_ovf),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got_v, input int exp_v);
    vectors++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  // Mean of a block rounded half toward +inf, using floor division.
  function automatic int ref_avg(input int s);
    int num;
    int q;
    num = s + NDEC / 2;
    q   = num / NDEC;
    if ((num % NDEC) != 0 && num < 0) q = q - 1;
    if (q > 8191)  q = 8191;
    if (q < -8192) q = -8192;
    return q;
  endfunction

  task automatic model_edge(input bit v, input int d, input bit rdy, input bit clr, input bit rst);
    bit popped;
    bit was_full;
    bit dump;
    bit drop;
    int res;
    int s;
    if (rst) begin
      mq.delete();
      blk.delete();
      m_ovf  = 1'b0;
      m_last = 0;
      return;
    end
    popped   = (mq.size() > 0) && rdy;
    was_full = (mq.size() == DEPTH);
    dump     = 1'b0;
    res      = 0;
    if (v) begin
      blk.push_back(d);
      if (blk.size() == NDEC) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
        res  = ref_avg(s);
        dump = 1'b1;
        blk.delete();
      end
    end
    drop = dump && was_full && !popped;
    if (popped) void'(mq.pop_front());
    if (dump && !drop) mq.push_back(res);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic step(input bit v, input int d, input bit rdy, input bit clr, input bit rst);
    in_valid   = v;
    data_in    = 14'(d);
    dout_ready = rdy;
    clr_ovf    = clr;
    if (!rst && !reset && dout_valid && rdy) got.push_back(int'(dout));
    reset      = rst;
    @(posedge clk);
    model_edge(v, d, rdy, clr, rst);
    #1;
    check("dout_valid", int'(dout_valid), int'(mq.size() > 0));
    check("fifo_level", int'(fifo_level), mq.size());
    check("overflow", int'(overflow), int'(m_ovf));
    check("dout", int'(dout), (mq.size() > 0) ? mq[0] : m_last);
  endtask

  task automatic feed(input int d, input bit rdy);
    step(1'b1, d, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, rdy, 1'b0, 1'b0);
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) check(tag, got[i], expq[i]);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    data_in    = '0;
    clr_ovf    = 1'b0;
    dout_ready = 1'b0;
    m_ovf      = 1'b0;
    m_last     = 0;

    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("rst_level", int'(fifo_level), 0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Single block, single output one cycle after the last sample.
    got.delete();
    feed(1, 1'b1); feed(0, 1'b1); feed(0, 1'b1); feed(1, 1'b1);
    check("tp1_valid", int'(dout_valid), 1);
    check("tp1_dout", int'(dout), 1);
    idle(1, 1'b1);
    check("tp1_valid_drop", int'(dout_valid), 0);
    idle(1, 1'b1);
    expq = '{1};
    check_got("tp1_out");

    // Rounding and extremes.
    got.delete();
    feed(-1, 1'b1); feed(-1, 1'b1); feed(0, 1'b1); feed(0, 1'b1);
    feed(-1, 1'b1); feed(-1, 1'b1); feed(-1, 1'b1); feed(0, 1'b1);
    for (int i = 0; i < 4; i++) feed(8191, 1'b1);
    for (int i = 0; i < 4; i++) feed(-8192, 1'b1);
    idle(3, 1'b1);
    expq = '{0, -1, 8191, -8192};
    check_got("round_out");

    // Overflow on a full FIFO, drain, then clear.
    got.delete();
    for (int i = 0; i < 20; i++) feed(100, 1'b0);
    check("ovf_level", int'(fifo_level), 4);
    check("ovf_flag", int'(overflow), 1);
    idle(6, 1'b1);
    expq = '{100, 100, 100, 100};
    check_got("drain_out");
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("ovf_clr", int'(overflow), 0);

    // Full FIFO with a dump and a pop on the same edge.
    got.delete();
    for (int b = 1; b <= 4; b++)
      for (int i = 0; i < 4; i++) feed(10 * b, 1'b0);
    feed(50, 1'b0); feed(50, 1'b0); feed(50, 1'b0);
    feed(50, 1'b1);
    check("fullpp_level", int'(fifo_level), 4);
    check("fullpp_ovf", int'(overflow), 0);
    idle(6, 1'b1);
    expq = '{10, 20, 30, 40, 50};
    check_got("fullpp_out");

    // Gapped input stream.
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      idle($urandom_range(0, 2), 1'b1);
      feed(10 * i, 1'b1);
    end
    idle(3, 1'b1);
    expq = '{25, 65};
    check_got("gap_out");

    // Reset in the middle of a block discards the partial sum.
    got.delete();
    feed(50, 1'b1); feed(50, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    check("midrst_dout", int'(dout), 0);
    step(1'b1, 9, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) feed(7, 1'b1);
    idle(2, 1'b1);
    expq = '{7};
    check_got("midrst_out");

    // Random traffic with backpressure, clears and rare resets.
    for (int c = 0; c < 1500; c++) begin
      bit v;
      bit rdy;
      bit clr;
      bit rst;
      int d;
      v   = ($urandom_range(0, 3) != 0);
      d   = int'($urandom_range(0, 16383)) - 8192;
      rdy = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(v, d, rdy, clr, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
